fetch_ctrl: RTL and testbench

- Front-end sequencer that owns the architectural fetch PC and drives the instruction-memory request/response handshake.
- Arbitrates the redirect sources (exception trap, relative branch, absolute jump) and discards stale in-flight fetches.
- Presents fetched instructions to decode through a one-entry valid/ready output slot.
- Sits between imem and the decode stage and replaces free-running PC stepping with a handshake-aware controller.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_redirect_sel.sv | 38 +++
 rtl/fetch_ctrl.sv | 105 ++++++++++
 tb/tb_fetch_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam int unsigned XLEN = 64;
  localparam logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000;

  // Fetch sequencer states; at most one imem request is outstanding in WAIT/DRAIN.
  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN
  } fetch_state_e;

  // Which redirect source won arbitration this cycle.
  typedef enum logic [1:0] {
    REDIR_NONE,
    REDIR_EXC,
    REDIR_BR,
    REDIR_JMP
  } redir_src_e;

endpackage

// File: rtl/fetch_redirect_sel.sv
// Priority selection of the PC redirect target: trap over branch over jump.
module fetch_redirect_sel
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN = fetch_pkg::XLEN
) (
  input  logic            exc_valid,
  input  logic [XLEN-1:0] mtvec,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_base,
  input  logic [XLEN-1:0] br_imm,
  input  logic            jmp_valid,
  input  logic [XLEN-1:0] jmp_target,
  output logic            redir,
  output logic [XLEN-1:0] target
);

  redir_src_e src;

  // Pick the winning source and form its target; branch sum wraps silently.
  always_comb begin
    src    = REDIR_NONE;
    target = '0;
    if (exc_valid) begin
      src    = REDIR_EXC;
      target = mtvec;
    end else if (br_valid) begin
      src    = REDIR_BR;
      target = br_base + br_imm;
    end else if (jmp_valid) begin
      src    = REDIR_JMP;
      target = jmp_target;
    end
  end

  assign redir = (src != REDIR_NONE);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, runs the imem req/gnt/rvalid handshake,
// drops responses made stale by a redirect, and feeds decode via a one-entry slot.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(fetch_pkg::RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exc_valid,
  input  logic [XLEN-1:0] mtvec,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_base,
  input  logic [XLEN-1:0] br_imm,
  input  logic            jmp_valid,
  input  logic [XLEN-1:0] jmp_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_inst,
  input  logic            id_ready
);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic            redir;
  logic [XLEN-1:0] target;
  logic            fire;
  logic            consume;
  logic            load;

  fetch_redirect_sel #(
    .XLEN(XLEN)
  ) u_redirect_sel (
    .exc_valid (exc_valid),
    .mtvec     (mtvec),
    .br_valid  (br_valid),
    .br_base   (br_base),
    .br_imm    (br_imm),
    .jmp_valid (jmp_valid),
    .jmp_target(jmp_target),
    .redir     (redir),
    .target    (target)
  );

  // Only request when the slot will be free by the time the response lands.
  assign imem_req  = (state == REQ) && (!if_valid || id_ready);
  assign imem_addr = pc;
  assign fire      = imem_req && imem_gnt;
  assign consume   = if_valid && id_ready;
  assign load      = (state == WAIT) && imem_rvalid && !redir;

  // Sequencer state, fetch PC and decode slot; a redirect flushes the slot ahead of load/consume.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_inst  <= '0;
    end else begin
      if (redir) begin
        if_valid <= 1'b0;
      end else if (load) begin
        if_valid <= 1'b1;
        if_pc    <= pc;
        if_inst  <= imem_rdata;
      end else if (consume) begin
        if_valid <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          state <= REQ;
          if (redir) pc <= target;
        end
        REQ: begin
          if (redir) pc <= target;
          // A grant racing a redirect still leaves a response in flight that must be dropped.
          if (fire) state <= redir ? DRAIN : WAIT;
        end
        WAIT: begin
          if (redir) begin
            pc    <= target;
            state <= imem_rvalid ? REQ : DRAIN;
          end else if (imem_rvalid) begin
            pc    <= pc + XLEN'(4);
            state <= REQ;
          end
        end
        DRAIN: begin
          if (redir) pc <= target;
          if (imem_rvalid) state <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus random traffic against a
// behavioural model tracking PC, one outstanding fetch and the decode slot.
module tb_fetch_ctrl;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exc_valid = 1'b0;
  logic [63:0] mtvec = '0;
  logic        br_valid = 1'b0;
  logic [63:0] br_base = '0;
  logic [63:0] br_imm = '0;
  logic        jmp_valid = 1'b0;
  logic [63:0] jmp_target = '0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_inst;
  logic        id_ready = 1'b0;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .XLEN(64),
    .RESET_PC(RST_PC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .exc_valid  (exc_valid),
    .mtvec      (mtvec),
    .br_valid   (br_valid),
    .br_base    (br_base),
    .br_imm     (br_imm),
    .jmp_valid  (jmp_valid),
    .jmp_target (jmp_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_inst    (if_inst),
    .id_ready   (id_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: started = left the post-reset idle cycle; pend = a fetch is in flight;
  // stale = that in-flight fetch was overtaken by a redirect.
  bit          m_started, m_pend, m_stale, m_sv;
  logic [63:0] m_pc, m_spc;
  logic [31:0] m_sinst;

  // Memory environment: one outstanding access, response after 'lat' cycles.
  bit          e_out;
  int          e_cnt;
  logic [63:0] e_addr;
  int          lat = 1;
  logic [63:0] glog[$];

  // Stimulus for the next cycle.
  bit          s_exc, s_br, s_jmp, s_ready, s_gnt;
  logic [63:0] s_mtvec, s_base, s_imm, s_jt;

  function automatic logic [31:0] word_at(input logic [63:0] a);
    return {a[15:0], a[31:16]} ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_b(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_stim();
    s_exc = 0; s_br = 0; s_jmp = 0; s_ready = 0; s_gnt = 0;
    s_mtvec = '0; s_base = '0; s_imm = '0; s_jt = '0;
  endtask

  task automatic model_reset();
    m_started = 0; m_pend = 0; m_stale = 0; m_sv = 0;
    m_pc = RST_PC; m_spc = '0; m_sinst = '0;
    e_out = 0; e_cnt = 0; e_addr = '0;
    glog.delete();
  endtask

  // Asynchronous reset applied between clock edges; outputs must clear immediately.
  task automatic do_reset();
    clear_stim();
    exc_valid = 0; br_valid = 0; jmp_valid = 0;
    imem_gnt = 0; imem_rvalid = 0; id_ready = 0;
    rst = 1'b0;
    #1;
    chk_b("rst_imem_req", imem_req, 1'b0);
    chk("rst_imem_addr", imem_addr, RST_PC);
    chk_b("rst_if_valid", if_valid, 1'b0);
    chk("rst_if_pc", if_pc, 64'd0);
    chk("rst_if_inst", 64'(if_inst), 64'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // One clock cycle: drive, check the combinational request, advance model, check registers.
  task automatic step();
    bit          redir, rv, req, fire, consume, ld;
    logic [63:0] tgt;
    bit          n_pend, n_stale, n_sv;
    logic [63:0] n_pc, n_spc;
    logic [31:0] n_sinst;

    exc_valid  = s_exc;  mtvec   = s_mtvec;
    br_valid   = s_br;   br_base = s_base;  br_imm = s_imm;
    jmp_valid  = s_jmp;  jmp_target = s_jt;
    id_ready   = s_ready;
    imem_gnt   = s_gnt;
    rv          = e_out && (e_cnt == 0);
    imem_rvalid = rv;
    imem_rdata  = rv ? word_at(e_addr) : $urandom;
    #1;

    redir = s_exc || s_br || s_jmp;
    tgt   = s_exc ? s_mtvec : (s_br ? s_base + s_imm : s_jt);
    req   = m_started && !m_pend && (!m_sv || s_ready);
    chk_b("imem_req", imem_req, req);
    fire    = req && s_gnt;
    ld      = m_pend && !m_stale && rv && !redir;
    consume = m_sv && s_ready;

    n_sv = m_sv && !consume; n_spc = m_spc; n_sinst = m_sinst; n_pc = m_pc;
    if (ld) begin
      n_sv = 1; n_spc = m_pc; n_sinst = imem_rdata; n_pc = m_pc + 64'd4;
    end
    if (redir) begin
      n_sv = 0; n_pc = tgt;
    end
    n_pend = m_pend; n_stale = m_stale;
    if (m_pend && rv) begin
      n_pend = 0; n_stale = 0;
    end else if (m_pend && redir) begin
      n_stale = 1;
    end
    if (fire) begin
      n_pend = 1; n_stale = redir;
    end

    if (rv) e_out = 0;
    else if (e_out) e_cnt--;
    if (imem_req && imem_gnt) begin
      e_out = 1; e_addr = imem_addr; e_cnt = lat - 1;
      glog.push_back(imem_addr);
    end

    @(posedge clk);
    m_started = 1; m_pend = n_pend; m_stale = n_stale;
    m_sv = n_sv; m_spc = n_spc; m_sinst = n_sinst; m_pc = n_pc;
    #1;
    chk("imem_addr", imem_addr, m_pc);
    chk_b("if_valid", if_valid, m_sv);
    chk("if_pc", if_pc, m_spc);
    chk("if_inst", 64'(if_inst), 64'(m_sinst));
  endtask

  initial begin
    clear_stim();
    model_reset();
    #2;

    // Straight-line fetch: grants at 8000_0000, _0004, _0008.
    do_reset();
    lat = 1; s_ready = 1; s_gnt = 1;
    repeat (7) step();
    chk("seq_g0", glog[0], 64'h8000_0000);
    chk("seq_g1", glog[1], 64'h8000_0004);
    chk("seq_g2", glog[2], 64'h8000_0008);
    chk("seq_cnt", 64'(glog.size()), 64'd3);
    chk("seq_if_pc", if_pc, 64'h8000_0008);

    // Decode stall holds the slot and suppresses requests.
    do_reset();
    lat = 1; s_ready = 0; s_gnt = 1;
    repeat (3) step();
    repeat (3) begin
      step();
      chk_b("stall_req", imem_req, 1'b0);
      chk_b("stall_valid", if_valid, 1'b1);
      chk("stall_pc", if_pc, RST_PC);
      chk("stall_inst", 64'(if_inst), 64'(word_at(RST_PC)));
      chk("stall_addr", imem_addr, 64'h8000_0004);
    end
    s_ready = 1;
    step();
    chk("unstall_grant", glog[$], 64'h8000_0004);
    chk("unstall_cnt", 64'(glog.size()), 64'd2);

    // Branch during WAIT with a slow response: drain, then fetch the target.
    do_reset();
    lat = 3; s_ready = 1; s_gnt = 1;
    repeat (2) step();
    s_br = 1; s_base = 64'h8000_0100; s_imm = 64'hFFFF_FFFF_FFFF_FFF8;
    step();
    chk("drain_addr", imem_addr, 64'h8000_00F8);
    chk_b("drain_valid0", if_valid, 1'b0);
    s_br = 0;
    repeat (3) begin
      step();
      chk_b("drain_no_slot", if_valid, 1'b0);
    end
    chk("drain_grant", glog[$], 64'h8000_00F8);
    chk("drain_cnt", 64'(glog.size()), 64'd2);

    // Priority: exception beats branch and jump; then branch beats jump.
    do_reset();
    s_ready = 1; s_gnt = 0; lat = 1;
    s_exc = 1; s_br = 1; s_jmp = 1;
    s_mtvec = 64'h8000_0400; s_base = 64'h8000_0100; s_imm = 64'hFFFF_FFFF_FFFF_FFF8;
    s_jt = 64'h8000_0800;
    step();
    chk("prio_exc_addr", imem_addr, 64'h8000_0400);
    clear_stim(); s_ready = 1; s_gnt = 1;
    step();
    chk("prio_exc_grant", glog[$], 64'h8000_0400);
    step();
    s_gnt = 0; s_br = 1; s_jmp = 1;
    s_base = 64'h8000_1000; s_imm = 64'h20; s_jt = 64'h8000_3000;
    step();
    chk("prio_br_addr", imem_addr, 64'h8000_1020);
    clear_stim(); s_ready = 1; s_gnt = 1;
    step();
    chk("prio_br_grant", glog[$], 64'h8000_1020);

    // Redirect coinciding with rvalid drops the word; flush beats consume; PC wraps.
    do_reset();
    lat = 1; s_ready = 1; s_gnt = 1;
    repeat (2) step();
    s_jmp = 1; s_jt = 64'h8000_0200;
    step();
    chk_b("same_cyc_valid", if_valid, 1'b0);
    chk("same_cyc_addr", imem_addr, 64'h8000_0200);
    s_jmp = 0;
    step();
    chk("same_cyc_grant", glog[$], 64'h8000_0200);
    step();
    chk_b("reload_valid", if_valid, 1'b1);
    chk("reload_pc", if_pc, 64'h8000_0200);
    s_exc = 1; s_mtvec = 64'h8000_0500; s_gnt = 0;
    step();
    chk_b("flush_valid", if_valid, 1'b0);
    chk("flush_addr", imem_addr, 64'h8000_0500);
    s_exc = 0; s_jmp = 1; s_jt = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    s_jmp = 0; s_gnt = 1;
    step();
    step();
    chk("wrap_addr", imem_addr, 64'd0);
    chk("wrap_if_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);

    // Asynchronous reset while a fetch is outstanding.
    do_reset();
    lat = 1; s_ready = 1; s_gnt = 1;
    repeat (3) step();
    lat = 3;
    step();
    chk("pre_rst_addr", imem_addr, 64'h8000_0004);
    do_reset();
    lat = 1; s_ready = 1; s_gnt = 1;
    repeat (2) step();
    chk("post_rst_grant", glog[$], RST_PC);
    chk("post_rst_cnt", 64'(glog.size()), 64'd1);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      s_ready = ($urandom_range(0, 9) < 7);
      s_gnt   = ($urandom_range(0, 9) < 6);
      s_exc   = ($urandom_range(0, 99) < 4);
      s_br    = ($urandom_range(0, 99) < 6);
      s_jmp   = ($urandom_range(0, 99) < 6);
      s_mtvec = {$urandom, $urandom};
      s_base  = {$urandom, $urandom};
      s_imm   = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom}
                                             : 64'($signed($urandom_range(0, 255)) - 128);
      s_jt    = {$urandom, $urandom};
      lat     = int'($urandom_range(1, 3));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
